// File: rtl/nios2_debug_pkg.sv
// Shared constants and types for the OCI debug-memory controller:
// jdo command bit positions, register-window layout and FSM states.
package nios2_debug_pkg;

  localparam int JDO_RD     = 36;
  localparam int JDO_GO     = 35;
  localparam int JDO_CLR_RE = 34;
  localparam int JDO_CLR_RL = 33;

  localparam int REG_READY  = 0;
  localparam int REG_ERROR  = 1;
  localparam int REG_GO     = 2;
  localparam int REG_RLATCH = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    J_RD  = 3'd1,
    J_CAP = 3'd2,
    J_WR  = 3'd3,
    C_RD  = 3'd4,
    C_CAP = 3'd5
  } state_e;

  function automatic logic [31:0] reg_word(input logic rlatch, input logic go,
                                           input logic err, input logic rdy);
    logic [31:0] w;
    w             = '0;
    w[REG_READY]  = rdy;
    w[REG_ERROR]  = err;
    w[REG_GO]     = go;
    w[REG_RLATCH] = rlatch;
    return w;
  endfunction

endpackage

// File: rtl/nios2_debug_ocimem_ctrl_if.sv
// CPU-side Avalon debug-slave port of the OCI memory controller, plus the
// controller's FSM state exported for observation.
interface nios2_debug_ocimem_ctrl_if #(
  parameter int AW = 8
);
  import nios2_debug_pkg::*;

  // A read or write is accepted in the cycle where it is asserted and
  // waitrequest is low; the master holds address/data/controls stable
  // while waitrequest is high. Read data is valid only in that same cycle.
  logic [AW:0]   address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic          debugaccess;
  logic [31:0]   readdata;
  logic          waitrequest;
  state_e        dbg_state;

  modport master (
    output address, read, write, writedata, byteenable, debugaccess,
    input  readdata, waitrequest, dbg_state
  );

  modport slave (
    input  address, read, write, writedata, byteenable, debugaccess,
    output readdata, waitrequest, dbg_state
  );

endinterface

// File: rtl/nios2_debug_ocimem_ram.sv
// Single-port byte-enabled monitor RAM; the address is registered, so read
// data appears one cycle after the address is presented.
module nios2_debug_ocimem_ram #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0]   mem_q [MEM_WORDS];
  logic [AW-1:0] addr_q;

  always_ff @(posedge clk) begin
    addr_q <= addr_i;
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_q];

endmodule

// File: rtl/nios2_debug_ocimem_ctrl.sv
// Sysclk-side OCI debug memory controller: executes JTAG memory commands,
// owns the monitor handshake flags and shares the RAM with the CPU port.
module nios2_debug_ocimem_ctrl
  import nios2_debug_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [37:0]                 jdo,
  input  logic                        take_action_ocimem_a,
  input  logic                        take_no_action_ocimem_a,
  input  logic                        take_action_ocimem_b,
  input  logic                        cpu_reset_event,
  nios2_debug_ocimem_ctrl_if.slave    avl,
  output logic [31:0]                 MonDReg,
  output logic                        monitor_ready,
  output logic                        monitor_error,
  output logic                        monitor_go,
  output logic                        resetlatch
);

  state_e        state_q, state_d;
  logic [AW-1:0] mon_a_q, mon_a_d;
  logic [31:0]   mon_d_q, mon_d_d;
  logic          go_q, go_d, ready_q, ready_d, error_q, error_d, rlatch_q, rlatch_d;

  logic          strobe_any, idle, strobe_drop, act_a, act_b, start_jrd;
  logic          reg_sel, ram_rd_req, ram_wr_req, reg_wr;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata, ram_q;
  logic          unused_jdo;

  assign strobe_any  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign idle        = (state_q == IDLE);
  assign strobe_drop = strobe_any & ~idle;
  assign act_a       = take_action_ocimem_a & idle;
  assign act_b       = take_action_ocimem_b & idle;
  assign start_jrd   = idle & (take_no_action_ocimem_a | (take_action_ocimem_a & jdo[JDO_RD]));
  assign reg_sel     = avl.address[AW];
  assign ram_rd_req  = avl.read & ~reg_sel;
  assign ram_wr_req  = avl.write & ~reg_sel;
  assign reg_wr      = avl.write & avl.debugaccess & reg_sel;
  assign unused_jdo  = jdo[37] ^ jdo[32];

  nios2_debug_ocimem_ram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // JTAG strobes claim the RAM first; a CPU read only starts in a strobe-free cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_jrd)                              state_d = J_RD;
        else if (take_action_ocimem_b)              state_d = J_WR;
        else if (ram_rd_req && !strobe_any)         state_d = C_RD;
      end
      J_RD:    state_d = J_CAP;
      J_CAP:   state_d = IDLE;
      J_WR:    state_d = IDLE;
      C_RD:    state_d = C_CAP;
      C_CAP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = avl.address[AW-1:0];
    ram_we    = 1'b0;
    ram_be    = avl.byteenable;
    ram_wdata = avl.writedata;
    if (act_b) begin
      ram_addr  = mon_a_q;
      ram_we    = ~reset;
      ram_be    = 4'hF;
      ram_wdata = jdo[31:0];
    end else if (state_q == J_RD) begin
      ram_addr  = mon_a_q;
    end else if (idle && !strobe_any && ram_wr_req && avl.debugaccess) begin
      ram_we    = ~reset;
    end

    if (reset)           avl.waitrequest = 1'b1;
    else if (ram_rd_req) avl.waitrequest = (state_q != C_CAP);
    else if (ram_wr_req) avl.waitrequest = ~idle | strobe_any;
    else                 avl.waitrequest = 1'b0;

    avl.readdata  = reg_sel ? reg_word(rlatch_q, go_q, error_q, ready_q) : ram_q;
    avl.dbg_state = state_q;
  end

  // Later assignments win: JTAG clears beat CPU sets, a CPU reset beats any clear.
  always_comb begin
    mon_a_d  = mon_a_q;
    mon_d_d  = mon_d_q;
    go_d     = go_q;
    ready_d  = ready_q;
    error_d  = error_q;
    rlatch_d = rlatch_q;

    if (act_a) mon_a_d = jdo[AW+1:2];
    if (act_b) begin
      mon_d_d = jdo[31:0];
      mon_a_d = mon_a_q + AW'(1);
    end
    if (state_q == J_CAP) begin
      mon_d_d = ram_q;
      mon_a_d = mon_a_q + AW'(1);
    end

    if (reg_wr && avl.writedata[REG_READY])  ready_d  = 1'b1;
    if (reg_wr && avl.writedata[REG_ERROR])  error_d  = 1'b1;
    if (reg_wr && avl.writedata[REG_GO])     go_d     = 1'b0;
    if (reg_wr && avl.writedata[REG_RLATCH]) rlatch_d = 1'b0;
    if (strobe_drop)                         error_d  = 1'b1;
    if (act_a && jdo[JDO_GO])                go_d     = 1'b1;
    if (act_a && jdo[JDO_CLR_RE]) begin
      ready_d = 1'b0;
      error_d = 1'b0;
    end
    if (act_a && jdo[JDO_CLR_RL])            rlatch_d = 1'b0;
    if (cpu_reset_event)                     rlatch_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mon_a_q  <= '0;
      mon_d_q  <= '0;
      go_q     <= 1'b0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      rlatch_q <= 1'b0;
    end else begin
      mon_a_q  <= mon_a_d;
      mon_d_q  <= mon_d_d;
      go_q     <= go_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
      rlatch_q <= rlatch_d;
    end
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign monitor_go    = go_q;
  assign resetlatch    = rlatch_q;

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Bench for the OCI debug memory controller: a word-array memory model and
// flag model track every JTAG command and CPU access issued.
module tb_nios2_debug_ocimem_ctrl;
  import nios2_debug_pkg::*;

  localparam int MEM_WORDS = 256;
  localparam int AW        = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_a = 1'b0, take_na = 1'b0, take_b = 1'b0, cpu_rst_ev = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, monitor_go, resetlatch;

  nios2_debug_ocimem_ctrl_if #(.AW(AW)) avl_if ();

  nios2_debug_ocimem_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_na),
    .take_action_ocimem_b    (take_b),
    .cpu_reset_event         (cpu_rst_ev),
    .avl                     (avl_if),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .monitor_go              (monitor_go),
    .resetlatch              (resetlatch)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_mem [MEM_WORDS];
  int          m_a;
  logic [31:0] m_d;
  logic        m_go, m_rdy, m_err, m_rl;
  int          total = 0;
  int          bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_jread();
    m_d = m_mem[m_a];
    m_a = (m_a + 1) % MEM_WORDS;
  endtask

  function automatic logic [37:0] mk_a(input int addr, input logic rd, input logic go,
                                       input logic clr_re, input logic clr_rl);
    logic [37:0] j;
    j             = {6'($urandom), 32'($urandom)};
    j[AW+1:2]     = addr[AW-1:0];
    j[JDO_RD]     = rd;
    j[JDO_GO]     = go;
    j[JDO_CLR_RE] = clr_re;
    j[JDO_CLR_RL] = clr_rl;
    return j;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input int a, input logic reg_win, input logic [31:0] d,
                           input logic [3:0] be, input logic dbg);
    int n;
    n = 0;
    avl_if.address     = {reg_win, a[AW-1:0]};
    avl_if.writedata   = d;
    avl_if.byteenable  = be;
    avl_if.debugaccess = dbg;
    avl_if.write       = 1'b1;
    @(negedge clk);
    while (avl_if.waitrequest === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL cpu_write_timeout addr=%0d waited=%0d limit=20", a, n);
    end
    @(posedge clk); #1;
    avl_if.write = 1'b0;
    if (dbg && reg_win) begin
      if (d[0]) m_rdy = 1'b1;
      if (d[1]) m_err = 1'b1;
      if (d[2]) m_go  = 1'b0;
      if (d[3]) m_rl  = 1'b0;
    end else if (dbg) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic cpu_read(input int a, input logic reg_win, output logic [31:0] d,
                          output int waits);
    waits = 0;
    avl_if.address = {reg_win, a[AW-1:0]};
    avl_if.read    = 1'b1;
    @(negedge clk);
    while (avl_if.waitrequest === 1'b1 && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    d = avl_if.readdata;
    @(posedge clk); #1;
    avl_if.read = 1'b0;
  endtask

  // kind: 0 = ocimem_a, 1 = read-next, 2 = write-data. Leaves 3 cycles of spacing.
  task automatic jtag_strobe(input int kind, input logic [37:0] j, output logic [31:0] d_mid);
    jdo = j;
    take_a  = (kind == 0);
    take_na = (kind == 1);
    take_b  = (kind == 2);
    tick();
    take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
    jdo = {6'($urandom), 32'($urandom)};
    tick();
    d_mid = MonDReg;
    tick();
    if (kind == 0) begin
      if (j[JDO_CLR_RE]) begin m_rdy = 1'b0; m_err = 1'b0; end
      if (j[JDO_GO])     m_go = 1'b1;
      if (j[JDO_CLR_RL]) m_rl = 1'b0;
      m_a = int'(j[AW+1:2]);
      if (j[JDO_RD]) model_jread();
    end else if (kind == 1) begin
      model_jread();
    end else begin
      m_mem[m_a] = j[31:0];
      m_d = j[31:0];
      m_a = (m_a + 1) % MEM_WORDS;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (avl_if.waitrequest !== 1'b1) begin
      bad++; $display("FAIL reset_waitreq got=%b exp=1", avl_if.waitrequest);
    end
    total++;
    if ({MonDReg, monitor_ready, monitor_error, monitor_go, resetlatch} !== 36'h0) begin
      bad++; $display("FAIL reset_outputs got=%h/%b%b%b%b exp=0", MonDReg,
                      monitor_ready, monitor_error, monitor_go, resetlatch);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (avl_if.dbg_state !== IDLE || avl_if.waitrequest !== 1'b0) begin
      bad++; $display("FAIL reset_release state=%0d wr=%b exp=IDLE/0",
                      avl_if.dbg_state, avl_if.waitrequest);
    end
    @(posedge clk); #1;
  endtask

  task automatic preload();
    for (int i = 0; i < MEM_WORDS; i++) cpu_write(i, 1'b0, $urandom, 4'hF, 1'b1);
  endtask

  task automatic test_cpu_write_jtag_read();
    logic [31:0] mid, prev;
    cpu_write(5, 1'b0, 32'hDEADBEEF, 4'hF, 1'b1);
    prev = MonDReg;
    jtag_strobe(0, mk_a(5, 1'b1, 1'b0, 1'b0, 1'b0), mid);
    total++;
    if (mid !== prev) begin
      bad++; $display("FAIL jrd_early got=%h exp=%h", mid, prev);
    end
    total++;
    if (MonDReg !== 32'hDEADBEEF) begin
      bad++; $display("FAIL jrd_data got=%h exp=%h", MonDReg, 32'hDEADBEEF);
    end
    jtag_strobe(1, {6'($urandom), 32'($urandom)}, mid);
    total++;
    if (MonDReg !== m_mem[6]) begin
      bad++; $display("FAIL jrd_next got=%h exp=%h", MonDReg, m_mem[6]);
    end
  endtask

  task automatic test_jtag_write_wrap();
    logic [31:0] mid, d;
    logic [37:0] j;
    int          w;
    jtag_strobe(0, mk_a(MEM_WORDS-1, 1'b0, 1'b0, 1'b0, 1'b0), mid);
    j = {6'($urandom), 32'($urandom)};
    j[31:0] = 32'h12345678;
    jtag_strobe(2, j, mid);
    total++;
    if (MonDReg !== 32'h12345678) begin
      bad++; $display("FAIL jwr_mondreg got=%h exp=%h", MonDReg, 32'h12345678);
    end
    jtag_strobe(1, {6'($urandom), 32'($urandom)}, mid);
    total++;
    if (MonDReg !== m_mem[0]) begin
      bad++; $display("FAIL jwr_wrap got=%h exp=%h", MonDReg, m_mem[0]);
    end
    cpu_read(MEM_WORDS-1, 1'b0, d, w);
    total++;
    if (d !== 32'h12345678 || w != 2) begin
      bad++; $display("FAIL jwr_cpu_read got=%h/%0d exp=%h/2", d, w, 32'h12345678);
    end
  endtask

  task automatic test_flags();
    logic [31:0] mid, d;
    int          w;
    jtag_strobe(0, mk_a(0, 1'b0, 1'b1, 1'b0, 1'b0), mid);
    total++;
    if (monitor_go !== 1'b1) begin bad++; $display("FAIL go_set got=%b exp=1", monitor_go); end
    cpu_write(0, 1'b1, 32'h4, 4'hF, 1'b1);
    total++;
    if (monitor_go !== 1'b0) begin bad++; $display("FAIL go_clr got=%b exp=0", monitor_go); end
    cpu_write(0, 1'b1, 32'h1, 4'hF, 1'b0);
    total++;
    if (monitor_ready !== 1'b0) begin
      bad++; $display("FAIL reg_nodbg got=%b exp=0", monitor_ready);
    end
    cpu_write(0, 1'b1, 32'h1, 4'hF, 1'b1);
    cpu_write(0, 1'b1, 32'h2, 4'hF, 1'b1);
    total++;
    if ({monitor_ready, monitor_error} !== 2'b11) begin
      bad++; $display("FAIL rdy_err_set got=%b%b exp=11", monitor_ready, monitor_error);
    end
    cpu_read(0, 1'b1, d, w);
    total++;
    if (d !== {28'h0, m_rl, m_go, m_err, m_rdy} || w != 0) begin
      bad++; $display("FAIL reg_read got=%h/%0d exp=%h/0", d, w, {28'h0, m_rl, m_go, m_err, m_rdy});
    end
    jtag_strobe(0, mk_a(0, 1'b0, 1'b0, 1'b1, 1'b0), mid);
    total++;
    if ({monitor_ready, monitor_error} !== 2'b00) begin
      bad++; $display("FAIL rdy_err_clr got=%b%b exp=00", monitor_ready, monitor_error);
    end
  endtask

  task automatic test_races();
    avl_if.address = {1'b1, AW'(0)}; avl_if.writedata = 32'h1;
    avl_if.debugaccess = 1'b1; avl_if.write = 1'b1;
    jdo = mk_a(0, 1'b0, 1'b0, 1'b1, 1'b0); take_a = 1'b1;
    tick();
    avl_if.write = 1'b0; take_a = 1'b0;
    tick(); tick();
    m_a = 0; m_rdy = 1'b0; m_err = 1'b0;
    total++;
    if (monitor_ready !== 1'b0) begin
      bad++; $display("FAIL clr_beats_set got=%b exp=0", monitor_ready);
    end
    cpu_rst_ev = 1'b1;
    jdo = mk_a(0, 1'b0, 1'b0, 1'b0, 1'b1); take_a = 1'b1;
    tick();
    cpu_rst_ev = 1'b0; take_a = 1'b0;
    tick(); tick();
    m_rl = 1'b1;
    total++;
    if (resetlatch !== 1'b1) begin
      bad++; $display("FAIL rstev_beats_clr got=%b exp=1", resetlatch);
    end
    cpu_write(0, 1'b1, 32'h8, 4'hF, 1'b1);
    total++;
    if (resetlatch !== 1'b0) begin
      bad++; $display("FAIL rlatch_cpu_clr got=%b exp=0", resetlatch);
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] d;
    int          waits, r;
    r = $urandom_range(0, MEM_WORDS-1);
    avl_if.address = {1'b0, r[AW-1:0]}; avl_if.read = 1'b1;
    jdo = {6'($urandom), 32'($urandom)}; take_na = 1'b1;
    waits = 0;
    @(negedge clk);
    while (avl_if.waitrequest === 1'b1 && waits < 20) begin
      waits++;
      @(posedge clk); #1;
      take_na = 1'b0;
      @(negedge clk);
    end
    d = avl_if.readdata;
    @(posedge clk); #1;
    avl_if.read = 1'b0;
    model_jread();
    total++;
    if (waits != 5) begin bad++; $display("FAIL arb_waits got=%0d exp=5", waits); end
    total++;
    if (d !== m_mem[r]) begin bad++; $display("FAIL arb_cpu_data got=%h exp=%h", d, m_mem[r]); end
    total++;
    if (MonDReg !== m_d) begin bad++; $display("FAIL arb_jtag_data got=%h exp=%h", MonDReg, m_d); end
  endtask

  task automatic test_drop();
    logic [31:0] d, mid;
    int          a0, w;
    a0 = m_a;
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
    jdo = {6'h0, ~m_mem[a0]}; take_b = 1'b1;
    tick();
    take_b = 1'b0;
    tick(); tick();
    model_jread();
    m_err = 1'b1;
    total++;
    if (monitor_error !== 1'b1 || MonDReg !== m_d) begin
      bad++; $display("FAIL drop got=%b/%h exp=1/%h", monitor_error, MonDReg, m_d);
    end
    cpu_read(a0, 1'b0, d, w);
    total++;
    if (d !== m_mem[a0]) begin bad++; $display("FAIL drop_mem got=%h exp=%h", d, m_mem[a0]); end
    jtag_strobe(1, {6'($urandom), 32'($urandom)}, mid);
    total++;
    if (MonDReg !== m_d) begin bad++; $display("FAIL drop_addr got=%h exp=%h", MonDReg, m_d); end
  endtask

  task automatic test_no_debugaccess();
    logic [31:0] d;
    int          r, w;
    r = $urandom_range(0, MEM_WORDS-1);
    cpu_write(r, 1'b0, ~m_mem[r], 4'hF, 1'b0);
    cpu_read(r, 1'b0, d, w);
    total++;
    if (d !== m_mem[r]) begin bad++; $display("FAIL nodbg_write got=%h exp=%h", d, m_mem[r]); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] mid;
    cpu_write(0, 1'b1, 32'h3, 4'hF, 1'b1);
    cpu_rst_ev = 1'b1; tick(); cpu_rst_ev = 1'b0;
    jtag_strobe(0, mk_a($urandom_range(1, MEM_WORDS-1), 1'b1, 1'b1, 1'b0, 1'b0), mid);
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    m_a = 0; m_d = '0; m_go = 1'b0; m_rdy = 1'b0; m_err = 1'b0; m_rl = 1'b0;
    total++;
    if ({MonDReg, monitor_ready, monitor_error, monitor_go, resetlatch} !== 36'h0 ||
        avl_if.dbg_state !== IDLE) begin
      bad++; $display("FAIL reset_mid_read got=%h/%b%b%b%b st=%0d exp=0/IDLE", MonDReg,
                      monitor_ready, monitor_error, monitor_go, resetlatch, avl_if.dbg_state);
    end
    jtag_strobe(1, {6'($urandom), 32'($urandom)}, mid);
    total++;
    if (MonDReg !== m_d) begin bad++; $display("FAIL post_reset_addr got=%h exp=%h", MonDReg, m_d); end
  endtask

  task automatic test_random();
    logic [31:0] d, mid, exp_w;
    logic [37:0] j;
    int          op, r, w;
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 5);
      r  = $urandom_range(0, MEM_WORDS-1);
      case (op)
        0: cpu_write(r, 1'b0, $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        1: begin
          cpu_read(r, 1'b0, d, w);
          total++;
          if (d !== m_mem[r] || w != 2) begin
            bad++; $display("FAIL rnd_cpu_read a=%0d got=%h/%0d exp=%h/2", r, d, w, m_mem[r]);
          end
        end
        2, 3, 4: begin
          if (op == 2) j = mk_a(r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
          else         j = {6'($urandom), 32'($urandom)};
          jtag_strobe(op - 2, j, mid);
          total++;
          if (MonDReg !== m_d || {monitor_go, monitor_ready, monitor_error, resetlatch} !==
              {m_go, m_rdy, m_err, m_rl}) begin
            bad++; $display("FAIL rnd_jtag op=%0d got=%h/%b%b%b%b exp=%h/%b%b%b%b", op, MonDReg,
                            monitor_go, monitor_ready, monitor_error, resetlatch,
                            m_d, m_go, m_rdy, m_err, m_rl);
          end
        end
        default: begin
          cpu_write(0, 1'b1, 32'($urandom_range(0, 15)), 4'hF, 1'b1);
          exp_w = {28'h0, m_rl, m_go, m_err, m_rdy};
          cpu_read(0, 1'b1, d, w);
          total++;
          if (d !== exp_w) begin bad++; $display("FAIL rnd_reg got=%h exp=%h", d, exp_w); end
        end
      endcase
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    avl_if.address = '0; avl_if.read = 1'b0; avl_if.write = 1'b0;
    avl_if.writedata = '0; avl_if.byteenable = 4'hF; avl_if.debugaccess = 1'b0;
    m_a = 0; m_d = '0; m_go = 1'b0; m_rdy = 1'b0; m_err = 1'b0; m_rl = 1'b0;
    test_reset();
    preload();
    test_cpu_write_jtag_read();
    test_jtag_write_wrap();
    test_flags();
    test_races();
    test_arbitration();
    test_drop();
    test_no_debugaccess();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
